// File: rtl/am_mod_core.sv
// AM modulator core: NCO carrier (phase accumulator + sine ROM) multiplied with a
// normalised offset-binary ADC stream through a 3-stage valid-tagged pipeline.
module am_mod_core #(
  parameter int DATA_W = 12,
  parameter int CAR_W = 8,
  parameter int PHASE_W = 32,
  parameter int LUT_AW = 8,
  parameter logic [PHASE_W-1:0] INC_DEFAULT = 32'h0100_0000,
  localparam int OUT_W = DATA_W + CAR_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [1:0]              mode,
  input  logic [7:0]              depth,
  input  logic                    inc_wr,
  input  logic [PHASE_W-1:0]      phase_inc,
  input  logic                    phase_rst,
  input  logic [PHASE_W-1:0]      phase_off,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic signed [CAR_W-1:0] car_out
);

  localparam int LUT_N = 1 << LUT_AW;
  localparam int XS_W = DATA_W + 1;
  localparam int E_W = DATA_W + 2;
  localparam int P_W = E_W + CAR_W;
  localparam logic signed [E_W-1:0] MID = E_W'(1 << (DATA_W - 1));

  // round((2^(CAR_W-1)-1) * sin(2*pi*k/2^LUT_AW)) via quarter-wave folding and a Q28 Taylor series
  function automatic logic signed [CAR_W-1:0] sine_entry(input int k);
    longint pi_q, x, x2, term, s, mag;
    int n, q, r, kf;
    pi_q = 64'sd843314857;
    n = 1 << LUT_AW;
    q = k >> (LUT_AW - 2);
    r = k % (n / 4);
    kf = q[0] ? (n / 4 - r) : r;
    x = (pi_q * 2 * longint'(kf)) / longint'(n);
    x2 = (x * x) >>> 28;
    s = x;
    term = x;
    for (int i = 1; i <= 7; i++) begin
      term = -((term * x2) >>> 28) / longint'((2 * i) * (2 * i + 1));
      s = s + term;
    end
    mag = (s * longint'((1 << (CAR_W - 1)) - 1) + (64'sd1 <<< 27)) >>> 28;
    return q[1] ? -CAR_W'(mag) : CAR_W'(mag);
  endfunction

  logic signed [CAR_W-1:0] sine_rom [LUT_N];

  for (genvar g = 0; g < LUT_N; g++) begin : g_rom
    assign sine_rom[g] = sine_entry(g);
  end

  logic [PHASE_W-1:0] acc, inc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc <= '0;
      inc <= INC_DEFAULT;
    end else begin
      if (phase_rst) acc <= phase_off;
      else if (en) acc <= acc + inc;
      if (inc_wr) inc <= phase_inc;
    end
  end

  logic                    v1;
  logic signed [XS_W-1:0]  xs1;
  logic [1:0]              mode1;
  logic [7:0]              depth1;
  logic [LUT_AW-1:0]       k1;

  // Offset-binary to two's complement is an MSB flip plus sign extension
  always_ff @(posedge CLK) begin
    if (RST) begin
      v1 <= 1'b0;
      xs1 <= '0;
      mode1 <= '0;
      depth1 <= '0;
      k1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        xs1 <= {~in_data[DATA_W-1], ~in_data[DATA_W-1], in_data[DATA_W-2:0]};
        mode1 <= mode;
        depth1 <= depth;
        k1 <= acc[PHASE_W-1 -: LUT_AW];
      end
    end
  end

  logic signed [XS_W+8:0] scaled;
  logic signed [E_W-1:0]  env;

  always_comb begin
    scaled = xs1 * $signed({1'b0, depth1});
    env = MID;
    case (mode1)
      2'b00, 2'b11: env = E_W'(xs1);
      2'b01:        env = MID + E_W'(scaled >>> 8);
      default:      env = MID;
    endcase
  end

  logic                    v2, bypass2;
  logic signed [E_W-1:0]   e2;
  logic signed [CAR_W-1:0] c2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      v2 <= 1'b0;
      e2 <= '0;
      c2 <= '0;
      bypass2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        e2 <= env;
        c2 <= sine_rom[k1];
        bypass2 <= (mode1 == 2'b11);
      end
    end
  end

  logic signed [CAR_W-1:0] car_eff;
  logic signed [P_W-1:0]   prod;

  always_comb begin
    car_eff = bypass2 ? CAR_W'(1) : c2;
    prod = e2 * car_eff;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      out_valid <= v2;
      if (v2) out_data <= OUT_W'(prod);
    end
  end

  // Monitor tap mirrors the sample path's two-register ROM pipeline
  logic [LUT_AW-1:0] car_addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      car_addr <= '0;
      car_out <= '0;
    end else begin
      car_addr <= acc[PHASE_W-1 -: LUT_AW];
      car_out <= sine_rom[car_addr];
    end
  end

endmodule
